rr_grant_scheduler: RTL and testbench

RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

---
 rtl/rr_sched_pkg.sv | 26 ++
 rtl/rr_prio_enc_16.sv | 40 ++++
 rtl/rr_grant_scheduler.sv | 127 ++++++++++++
 tb/tb_rr_grant_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_sched_pkg
// Purpose  : Shared constants and FSM state type for the round-robin grant
//            scheduler and its priority encoder.
// Contents : N_REQ, IDX_W, sched_state_t, next_idx()
// Revision : 1.0 - initial release
// ============================================================================
package rr_sched_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_GRANT  = 2'd2
  } sched_state_t;

  // Index following idx, wrapping naturally at the IDX_W-bit boundary.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage : rr_sched_pkg
`default_nettype wire

// File: rtl/rr_prio_enc_16.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_enc_16
// Purpose  : Combinational rotating priority encoder. Finds the first set
//            bit of mask at or above start, wrapping from bit 15 to bit 0.
// Ports    : mask  [15:0] in  - candidate bits
//            start [3:0]  in  - index where the search begins
//            idx   [3:0]  out - index of the first set bit found
//            found        out - high when mask has any bit set
// Revision : 1.0 - initial release
// ============================================================================
module rr_prio_enc_16 (
  input  logic [15:0] mask,
  input  logic [3:0]  start,
  output logic [3:0]  idx,
  output logic        found
);

  import rr_sched_pkg::*;

  logic [15:0] w_rot;
  logic [3:0]  w_off;

  always_comb begin
    // Rotate so that bit 'start' lands at position 0; the search then becomes
    // a plain lowest-set-bit scan and the offset is added back afterwards.
    w_rot = 16'({mask, mask} >> start);
    w_off = 4'd0;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (w_rot[i]) begin
        found = 1'b1;
        w_off = 4'(i);
      end
    end
    idx = start + w_off;
  end

endmodule : rr_prio_enc_16
`default_nettype wire

// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_scheduler
// Purpose  : Round-robin scheduler over 16 request lines. Requests are
//            captured into a pending mask; an IDLE/SELECT/GRANT FSM issues
//            one grant at a time with a valid/ready handshake, the most
//            recently served index getting lowest priority next time.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            req   [N_REQ-1:0] in  - request lines (level or pulse)
//            enable           in  - permits new grants to start
//            grant_ready      in  - consumer accepts the current grant
//            grant_valid      out - grant_idx is valid
//            grant_idx [IDX_W-1:0] out - index of granted requester
//            pending [N_REQ-1:0]   out - registered pending-request mask
//            busy             out - registered |pending
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
  parameter int N_REQ = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] pending,
  output logic             busy
);

  import rr_sched_pkg::*;

  sched_state_t     r_state;
  logic [N_REQ-1:0] r_pending;
  logic [IDX_W-1:0] r_last_idx;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;
  logic             r_busy;

  logic             w_accept;
  logic [N_REQ-1:0] w_clear;
  logic [N_REQ-1:0] w_pending_next;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_enc_idx;
  logic             w_enc_found;

  assign w_accept = r_grant_valid & grant_ready;
  assign w_clear  = w_accept ? (N_REQ'(1) << r_grant_idx) : '0;

  // Clear first, then OR in new requests so a re-request on the accept
  // edge keeps the bit pending.
  assign w_pending_next = (r_pending & ~w_clear) | req;

  // last_idx resets to 15, so the first search after reset starts at 0.
  assign w_start = next_idx(r_last_idx);

  rr_prio_enc_16 u_prio_enc (
    .mask  (r_pending),
    .start (w_start),
    .idx   (w_enc_idx),
    .found (w_enc_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_last_idx    <= IDX_W'(N_REQ - 1);
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      // busy tracks the registered mask, computed from its next value so
      // both flops change on the same edge.
      r_busy    <= |w_pending_next;

      case (r_state)
        ST_IDLE: begin
          if (enable && (|r_pending)) begin
            r_state <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          // Pending cannot drain outside GRANT, so found is expected high;
          // the fallback only guards against an empty mask.
          if (w_enc_found) begin
            r_grant_idx   <= w_enc_idx;
            r_grant_valid <= 1'b1;
            r_state       <= ST_GRANT;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_GRANT: begin
          // enable is deliberately ignored until acceptance: a grant that
          // has been offered is never withdrawn.
          if (w_accept) begin
            r_last_idx    <= r_grant_idx;
            r_grant_valid <= 1'b0;
            if (enable && (|w_pending_next)) begin
              r_state <= ST_SELECT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign pending     = r_pending;
  assign busy        = r_busy;

endmodule : rr_grant_scheduler
`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_scheduler
// Purpose  : Self-checking bench for rr_grant_scheduler: a cycle model of the
//            scheduling rules checked every cycle, plus directed scenarios
//            with hand-computed expectations, then randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_scheduler;

  localparam int P_IDLE   = 0;
  localparam int P_SELECT = 1;
  localparam int P_GRANT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        enable = 1'b0;
  logic        grant_ready = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] pending;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_grant_scheduler #(.N_REQ(16), .IDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .enable      (enable),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .pending     (pending),
    .busy        (busy)
  );

  // ---------------- reference model ----------------
  bit          m_known = 1'b0;
  logic [15:0] m_pend  = '0;
  int          m_last  = 15;
  int          m_phase = P_IDLE;
  bit          m_gv    = 1'b0;
  int          m_gidx  = 0;

  // First pending index after 'last', scanning upward with wrap.
  function automatic int rr_pick(input logic [15:0] p, input int last);
    for (int k = 1; k <= 16; k++) begin
      if (p[(last + k) % 16]) return (last + k) % 16;
    end
    return -1;
  endfunction

  initial begin
    logic        s_rst, s_en, s_rdy, acc;
    logic [15:0] s_req, np;
    int          pick;
    forever begin
      @(posedge clk);
      s_rst = rst; s_req = req; s_en = enable; s_rdy = grant_ready;
      if (s_rst) begin
        m_known = 1'b1; m_pend = '0; m_last = 15;
        m_phase = P_IDLE; m_gv = 1'b0; m_gidx = 0;
      end else if (m_known) begin
        acc = m_gv && s_rdy;
        np  = m_pend;
        if (acc) np[m_gidx] = 1'b0;
        np = np | s_req;
        case (m_phase)
          P_IDLE:   if (s_en && m_pend != 0) m_phase = P_SELECT;
          P_SELECT: begin
            pick = rr_pick(m_pend, m_last);
            if (pick >= 0) begin
              m_gidx = pick; m_gv = 1'b1; m_phase = P_GRANT;
            end else begin
              m_phase = P_IDLE;
            end
          end
          P_GRANT: if (acc) begin
            m_last  = m_gidx;
            m_gv    = 1'b0;
            m_phase = (s_en && np != 0) ? P_SELECT : P_IDLE;
          end
          default: m_phase = P_IDLE;
        endcase
        m_pend = np;
      end
      #1;
      if (m_known) begin
        n_tests++;
        if (grant_valid !== m_gv || grant_idx !== 4'(m_gidx) ||
            pending !== m_pend || busy !== (m_pend != 0)) begin
          n_fail++;
          $display("FAIL model_cycle t=%0t got gv=%b idx=%0d pend=%h busy=%b want gv=%b idx=%0d pend=%h busy=%b",
                   $time, grant_valid, grant_idx, pending, busy,
                   m_gv, m_gidx, m_pend, (m_pend != 0));
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_gv(input string nm);
    int k = 0;
    while (!grant_valid && k < 10) begin
      step();
      k++;
    end
    check(nm, int'(grant_valid), 1);
  endtask

  int gq[$];
  int cq[$];

  task automatic collect(input int cycles);
    gq.delete(); cq.delete();
    for (int k = 1; k <= cycles; k++) begin
      step();
      if (grant_valid && grant_ready) begin
        gq.push_back(int'(grant_idx));
        cq.push_back(k);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_b[4];
    int exp_w[2];
    int exp_r[2];

    // Reset state
    do_reset();
    check("reset_gv",   int'(grant_valid), 0);
    check("reset_idx",  int'(grant_idx),   0);
    check("reset_pend", int'(pending),     0);
    check("reset_busy", int'(busy),        0);

    // Single pulse: grant in cycle 3, cleared after acceptance
    enable = 1'b1; grant_ready = 1'b1; req = 16'h0001;
    step(); req = '0;
    check("pulse_c1_pend", int'(pending), 16'h0001);
    check("pulse_c1_busy", int'(busy), 1);
    check("pulse_c1_gv",   int'(grant_valid), 0);
    step();
    check("pulse_c2_gv",   int'(grant_valid), 0);
    step();
    check("pulse_c3_gv",   int'(grant_valid), 1);
    check("pulse_c3_idx",  int'(grant_idx), 0);
    step();
    check("pulse_c4_gv",   int'(grant_valid), 0);
    check("pulse_c4_pend", int'(pending), 0);
    check("pulse_c4_busy", int'(busy), 0);

    // Burst 0x8421 from reset: 0,5,10,15 two cycles apart
    do_reset();
    enable = 1'b1; grant_ready = 1'b1; req = 16'h8421;
    step(); req = '0;
    collect(12);
    exp_b = '{0, 5, 10, 15};
    check("burst_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      check($sformatf("burst_idx%0d", i), gq[i], exp_b[i]);
      check($sformatf("burst_cyc%0d", i), cq[i], 2 + 2 * i);
    end
    check("burst_end_gv",   int'(grant_valid), 0);
    check("burst_end_busy", int'(busy), 0);

    // Wrap: last_idx=10, pending=0x0401 -> 0 then 10
    do_reset();
    enable = 1'b1; grant_ready = 1'b1; req = 16'h0400;
    step(); req = '0;
    collect(6);
    check("wrap_setup_count", gq.size(), 1);
    req = 16'h0401;
    step(); req = '0;
    collect(10);
    exp_w = '{0, 10};
    check("wrap_count", gq.size(), 2);
    for (int i = 0; i < 2 && i < gq.size(); i++)
      check($sformatf("wrap_idx%0d", i), gq[i], exp_w[i]);

    // Backpressure: grant held for 5 cycles, enable dropped, re-request
    do_reset();
    enable = 1'b1; grant_ready = 1'b0; req = 16'h0008;
    step(); req = '0;
    wait_gv("bp_gv_seen");
    enable = 1'b0; req = 16'h0008;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold_gv%0d", i),  int'(grant_valid), 1);
      check($sformatf("bp_hold_idx%0d", i), int'(grant_idx), 3);
    end
    req = '0; enable = 1'b1; grant_ready = 1'b1;
    step();
    check("bp_accept_gv",   int'(grant_valid), 0);
    check("bp_accept_pend", int'(pending), 0);

    // Re-request on the accept edge: 1 accepted, then 2, then 1 again
    do_reset();
    enable = 1'b1; grant_ready = 1'b0; req = 16'h0006;
    step(); req = '0;
    wait_gv("rr_gv_seen");
    check("rr_first_idx", int'(grant_idx), 1);
    grant_ready = 1'b1; req = 16'h0002;
    step(); req = '0;
    check("rr_pend_after", int'(pending), 16'h0006);
    collect(10);
    exp_r = '{2, 1};
    check("rr_count", gq.size(), 2);
    for (int i = 0; i < 2 && i < gq.size(); i++)
      check($sformatf("rr_idx%0d", i), gq[i], exp_r[i]);

    // enable=0 holds requests without granting
    do_reset();
    enable = 1'b0; grant_ready = 1'b1; req = 16'h00F0;
    step(); req = '0;
    step(); step(); step();
    check("en0_busy", int'(busy), 1);
    check("en0_pend", int'(pending), 16'h00F0);
    check("en0_gv",   int'(grant_valid), 0);
    enable = 1'b1;
    step();
    check("en1_select_gv", int'(grant_valid), 0);
    step();
    check("en1_gv",  int'(grant_valid), 1);
    check("en1_idx", int'(grant_idx), 4);

    // Reset during GRANT, with requests asserted in the reset cycle
    do_reset();
    enable = 1'b1; grant_ready = 1'b0; req = 16'h0010;
    step(); req = '0;
    wait_gv("rst_gv_seen");
    rst = 1'b1; req = 16'hFFFF;
    step();
    rst = 1'b0; req = '0;
    check("rst_mid_gv",   int'(grant_valid), 0);
    check("rst_mid_pend", int'(pending), 0);
    check("rst_mid_busy", int'(busy), 0);
    step();
    check("rst_mid_idle_gv",   int'(grant_valid), 0);
    check("rst_mid_idle_pend", int'(pending), 0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 249) == 0);
      req         = ($urandom_range(0, 2) == 0) ? 16'(($urandom & $urandom) & $urandom) : 16'h0;
      enable      = ($urandom_range(0, 9) != 0);
      grant_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0; req = '0; enable = 1'b1; grant_ready = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_grant_scheduler
`default_nettype wire
